gpr_file_ext: RTL

Parametrised general-purpose register file for the RISC-V core, replacing the fixed 16/32-entry GPR block.
- Adds same-cycle write-to-read bypass on both core read ports.
- Adds a handshaked bus/debug read-write port that arbitrates against core writeback.
- Clears storage with a post-reset sweep FSM (one entry per cycle), so storage can map to distributed RAM.
- Flags accesses to addresses beyond the configured register count (RV32E mode).

---
 rtl/gpr_file_ext_pkg.sv | 27 ++
 rtl/gpr_file_ext_if.sv | 35 +++
 rtl/gpr_file_ext_rd_mux.sv | 27 ++
 rtl/gpr_file_ext.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/gpr_file_ext_pkg.sv
// Shared constants, FSM encodings and address helpers for the GPR file.
package gpr_file_ext_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Register counts for the two supported base ISAs
    localparam int NUM_REGS_RV32E = 16;
    localparam int NUM_REGS_RV32I = 32;

    // Bus/sweep FSM encodings
    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ACK    = 2'd3;

    // True when the address maps onto an implemented register
    function automatic logic addr_in_range(input logic [REG_ADDR_W-1:0] a, input int n);
        return int'(a) < n;
    endfunction

    // True when the address names a real, writable register (not x0, in range)
    function automatic logic addr_writable(input logic [REG_ADDR_W-1:0] a, input int n);
        return (a != '0) && addr_in_range(a, n);
    endfunction

endpackage

// File: rtl/gpr_file_ext_if.sv
// Core read/write and bus/debug port bundle of the GPR file.
interface gpr_file_ext_if #(
    parameter int XLEN = gpr_file_ext_pkg::XLEN
);
    logic [gpr_file_ext_pkg::REG_ADDR_W-1:0] raddr1_i;
    logic [gpr_file_ext_pkg::REG_ADDR_W-1:0] raddr2_i;
    logic [XLEN-1:0]                         rdata1_o;
    logic [XLEN-1:0]                         rdata2_o;
    logic                                    we_i;
    logic [gpr_file_ext_pkg::REG_ADDR_W-1:0] waddr_i;
    logic [XLEN-1:0]                         wdata_i;
    logic                                    bus_req_i;
    logic                                    bus_we_i;
    logic [gpr_file_ext_pkg::REG_ADDR_W-1:0] bus_addr_i;
    logic [XLEN-1:0]                         bus_wdata_i;
    logic [XLEN-1:0]                         bus_rdata_o;
    logic                                    bus_ack_o;
    logic                                    bus_err_o;
    logic                                    init_busy_o;

    // Core pipeline / bus requester side
    modport master (
        output raddr1_i, raddr2_i, we_i, waddr_i, wdata_i,
               bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i,
        input  rdata1_o, rdata2_o, bus_rdata_o, bus_ack_o, bus_err_o, init_busy_o
    );

    // Register file side
    modport slave (
        input  raddr1_i, raddr2_i, we_i, waddr_i, wdata_i,
               bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i,
        output rdata1_o, rdata2_o, bus_rdata_o, bus_ack_o, bus_err_o, init_busy_o
    );

endinterface

// File: rtl/gpr_file_ext_rd_mux.sv
// Core read port: zero for x0 / out-of-range / sweep, optional write bypass.
module gpr_rd_mux
    import gpr_file_ext_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter bit BYPASS   = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] raddr,
    input  logic                  init_busy,
    input  logic                  core_wr,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [XLEN-1:0]       store_data,
    output logic [XLEN-1:0]       rdata
);

    // core_wr is already qualified (enable, not x0, in range, not sweeping)
    always_comb begin
        rdata = store_data;
        if (init_busy || !addr_writable(raddr, NUM_REGS))
            rdata = '0;
        else if (BYPASS && core_wr && (waddr == raddr))
            rdata = wdata;
    end

endmodule

// File: rtl/gpr_file_ext.sv
// Parametrised GPR file: 2 core read ports with bypass, 1 core write port,
// handshaked bus port sharing the single storage write port, reset sweep.
module gpr_file_ext #(
    parameter int XLEN     = gpr_file_ext_pkg::XLEN,
    parameter int NUM_REGS = gpr_file_ext_pkg::NUM_REGS_RV32I,
    parameter bit BYPASS   = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    gpr_file_ext_if.slave  rf
);
    import gpr_file_ext_pkg::*;

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [1:0]            state;
    logic [REG_ADDR_W-1:0] cnt;
    logic [REG_ADDR_W-1:0] bus_addr;
    logic                  bus_we;
    logic [XLEN-1:0]       bus_wdata;
    logic [XLEN-1:0]       bus_rdata;
    logic                  bus_ack;
    logic                  bus_err;

    // Single write port and no reset so this can map to distributed RAM
    logic [XLEN-1:0]       regs [NUM_REGS];

    logic                  init_busy;
    logic                  core_wr;
    logic                  bus_in_range;
    logic [XLEN-1:0]       bus_rd_val;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]       wr_data;

    assign init_busy    = (state == ST_INIT);
    assign core_wr      = !init_busy && rf.we_i && addr_writable(rf.waddr_i, NUM_REGS);
    assign bus_in_range = addr_in_range(bus_addr, NUM_REGS);

    // Bus read value sees a same-cycle core write to the same register
    always_comb begin
        bus_rd_val = regs[bus_addr[IDX_W-1:0]];
        if (!addr_writable(bus_addr, NUM_REGS))
            bus_rd_val = '0;
        else if (core_wr && (rf.waddr_i == bus_addr))
            bus_rd_val = rf.wdata_i;
    end

    // Write-port arbitration: sweep, then core, then the bus (only when the
    // core is not writing at all, which keeps the two from ever colliding)
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (rst) begin
            wr_en = 1'b0;
        end else if (init_busy) begin
            wr_en   = 1'b1;
            wr_addr = cnt;
        end else if (core_wr) begin
            wr_en   = 1'b1;
            wr_addr = rf.waddr_i;
            wr_data = rf.wdata_i;
        end else if (state == ST_ACCESS && bus_we && !rf.we_i &&
                     addr_writable(bus_addr, NUM_REGS)) begin
            wr_en   = 1'b1;
            wr_addr = bus_addr;
            wr_data = bus_wdata;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (wr_en)
            regs[wr_addr[IDX_W-1:0]] <= wr_data;
    end

    // Sweep / bus handshake FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            cnt       <= '0;
            bus_ack   <= 1'b0;
            bus_err   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (int'(cnt) == NUM_REGS - 1)
                        state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (rf.bus_req_i) begin
                        bus_addr  <= rf.bus_addr_i;
                        bus_we    <= rf.bus_we_i;
                        bus_wdata <= rf.bus_wdata_i;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!bus_in_range) begin
                        bus_rdata <= '0;
                        bus_err   <= 1'b1;
                        bus_ack   <= 1'b1;
                        state     <= ST_ACK;
                    end else if (!bus_we) begin
                        bus_rdata <= bus_rd_val;
                        bus_ack   <= 1'b1;
                        state     <= ST_ACK;
                    end else if (!rf.we_i) begin
                        // write lands this cycle through the shared write port
                        bus_ack <= 1'b1;
                        state   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    bus_ack <= 1'b0;
                    bus_err <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    gpr_rd_mux #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS)) u_rd1 (
        .raddr      (rf.raddr1_i),
        .init_busy  (init_busy),
        .core_wr    (core_wr),
        .waddr      (rf.waddr_i),
        .wdata      (rf.wdata_i),
        .store_data (regs[rf.raddr1_i[IDX_W-1:0]]),
        .rdata      (rf.rdata1_o)
    );

    gpr_rd_mux #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS)) u_rd2 (
        .raddr      (rf.raddr2_i),
        .init_busy  (init_busy),
        .core_wr    (core_wr),
        .waddr      (rf.waddr_i),
        .wdata      (rf.wdata_i),
        .store_data (regs[rf.raddr2_i[IDX_W-1:0]]),
        .rdata      (rf.rdata2_o)
    );

    assign rf.bus_rdata_o = bus_rdata;
    assign rf.bus_ack_o   = bus_ack;
    assign rf.bus_err_o   = bus_err;
    assign rf.init_busy_o = init_busy;

endmodule
